// File: rtl/bcd_press_counter_if.sv
// Key, control and BCD result signals between the board key and the Nios II PIOs.
// The bench or board wrapper is the master; bcd_press_counter is the slave.
interface bcd_press_counter_if;
    logic       btn_n;
    logic       dir;
    logic       clr;
    logic [3:0] unites;
    logic [3:0] dizaines;
    logic [3:0] centaines;
    logic       evt_pulse;
    logic       wrap;

    modport master (
        output btn_n, dir, clr,
        input  unites, dizaines, centaines, evt_pulse, wrap
    );

    modport slave (
        input  btn_n, dir, clr,
        output unites, dizaines, centaines, evt_pulse, wrap
    );
endinterface

// File: rtl/bcd_press_counter.sv
// Debounced push-button press counter with three BCD digits, up/down and clear.
// Define BCD_PRESS_SAT_EN to saturate at 999/000 instead of wrapping.
module bcd_press_counter #(
    parameter int DB_CYCLES   = 500000,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    bcd_press_counter_if.slave  bus
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic                   accept;
    logic [SYNC_STAGES-1:0] sync;
    logic                   btn_s;

    logic [3:0] u_q, d_q, c_q;
    logic [3:0] u_nx, d_nx, c_nx;
    logic       evt_q, wrap_q;
    logic       roll, wrap_nx;

    // Ones at reset so a released key is seen while the chain refills
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) sync <= '1;
        else             sync <= {sync[SYNC_STAGES-2:0], bus.btn_n};
    end

    assign btn_s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!btn_s) begin
                    state_nx = PRESS_WAIT;
                    cnt_nx   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (btn_s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                    accept   = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            HELD: begin
                if (btn_s) begin
                    state_nx = REL_WAIT;
                    cnt_nx   = CW'(1);
                end
            end
            REL_WAIT: begin
                if (!btn_s) begin
                    state_nx = HELD;
                    cnt_nx   = '0;
                end else if (cnt == LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Ripple carry/borrow across the three digits
    always_comb begin
        u_nx = u_q;
        d_nx = d_q;
        c_nx = c_q;
        roll = 1'b0;
        if (!bus.dir) begin
            roll = (u_q == 4'd9) && (d_q == 4'd9) && (c_q == 4'd9);
            u_nx = (u_q == 4'd9) ? 4'd0 : u_q + 4'd1;
            if (u_q == 4'd9)
                d_nx = (d_q == 4'd9) ? 4'd0 : d_q + 4'd1;
            if (u_q == 4'd9 && d_q == 4'd9)
                c_nx = (c_q == 4'd9) ? 4'd0 : c_q + 4'd1;
        end else begin
            roll = (u_q == 4'd0) && (d_q == 4'd0) && (c_q == 4'd0);
            u_nx = (u_q == 4'd0) ? 4'd9 : u_q - 4'd1;
            if (u_q == 4'd0)
                d_nx = (d_q == 4'd0) ? 4'd9 : d_q - 4'd1;
            if (u_q == 4'd0 && d_q == 4'd0)
                c_nx = (c_q == 4'd0) ? 4'd9 : c_q - 4'd1;
        end
`ifdef BCD_PRESS_SAT_EN
        wrap_nx = 1'b0;
        if (roll) begin
            u_nx = u_q;
            d_nx = d_q;
            c_nx = c_q;
        end
`else
        wrap_nx = roll;
`endif
    end

    // Clear beats a simultaneous accept; that press is dropped entirely
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            u_q    <= '0;
            d_q    <= '0;
            c_q    <= '0;
            evt_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else if (bus.clr) begin
            u_q    <= '0;
            d_q    <= '0;
            c_q    <= '0;
            evt_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else if (accept) begin
            u_q    <= u_nx;
            d_q    <= d_nx;
            c_q    <= c_nx;
            evt_q  <= 1'b1;
            wrap_q <= wrap_nx;
        end else begin
            evt_q  <= 1'b0;
            wrap_q <= 1'b0;
        end
    end

    assign bus.unites    = u_q;
    assign bus.dizaines  = d_q;
    assign bus.centaines = c_q;
    assign bus.evt_pulse = evt_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_bcd_press_counter.sv
// Directed bench for bcd_press_counter with DB_CYCLES=4, SYNC_STAGES=2.
// Honours BCD_PRESS_SAT_EN for the saturating build.
module tb_bcd_press_counter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   evt_seen = 0;
    int   wrap_seen = 0;
    logic [11:0] got;

    bcd_press_counter_if bif ();

    bcd_press_counter #(.DB_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .bus         (bif.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bif.evt_pulse === 1'b1) evt_seen++;
        if (bif.wrap === 1'b1)      wrap_seen++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not end in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bif.btn_n = 1'b1;
        bif.dir = 1'b0;
        bif.clr = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic press();
        bif.btn_n = 1'b0;
        tick(10);
        bif.btn_n = 1'b1;
        tick(10);
    endtask

    task automatic test_reset();
        do_reset();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL reset_digits got %h want 000", got);
        end
        n_cmp++;
        if (bif.evt_pulse !== 1'b0) begin
            n_err++;
            $display("FAIL reset_evt got %b want 0", bif.evt_pulse);
        end
        n_cmp++;
        if (bif.wrap !== 1'b0) begin
            n_err++;
            $display("FAIL reset_wrap got %b want 0", bif.wrap);
        end
    endtask

    task automatic test_single();
        int hits;
        int pos;
        do_reset();
        hits = 0;
        pos = -1;
        bif.btn_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bif.evt_pulse === 1'b1) begin
                hits++;
                if (pos < 0) pos = k;
            end
        end
        bif.btn_n = 1'b1;
        tick(20);
        n_cmp++;
        if (pos !== 5) begin
            n_err++;
            $display("FAIL single_evt_edge got E+%0d want E+5", pos);
        end
        n_cmp++;
        if (hits !== 1) begin
            n_err++;
            $display("FAIL single_evt_width got %0d want 1", hits);
        end
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h001) begin
            n_err++;
            $display("FAIL single_digits got %h want 001", got);
        end
    endtask

    task automatic test_bounce();
        int e0;
        do_reset();
        e0 = evt_seen;
        bif.btn_n = 1'b0;
        tick(3);
        bif.btn_n = 1'b1;
        tick(1);
        bif.btn_n = 1'b0;
        tick(3);
        bif.btn_n = 1'b1;
        tick(20);
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL bounce_digits got %h want 000", got);
        end
        n_cmp++;
        if (evt_seen - e0 !== 0) begin
            n_err++;
            $display("FAIL bounce_evt got %0d want 0", evt_seen - e0);
        end
    endtask

    task automatic test_carry();
        int w0;
        do_reset();
        repeat (99) press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h099) begin
            n_err++;
            $display("FAIL carry_preload got %h want 099", got);
        end
        w0 = wrap_seen;
        press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h100) begin
            n_err++;
            $display("FAIL carry_up got %h want 100", got);
        end
        n_cmp++;
        if (wrap_seen - w0 !== 0) begin
            n_err++;
            $display("FAIL carry_wrap got %0d want 0", wrap_seen - w0);
        end
        bif.dir = 1'b1;
        press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h099) begin
            n_err++;
            $display("FAIL borrow_down got %h want 099", got);
        end
    endtask

    task automatic test_wrap();
        int w0;
        int e0;
        logic [11:0] exp_dn;
        logic [11:0] exp_up;
        int exp_w;
`ifdef BCD_PRESS_SAT_EN
        exp_dn = 12'h000;
        exp_up = 12'h001;
        exp_w  = 0;
`else
        exp_dn = 12'h999;
        exp_up = 12'h000;
        exp_w  = 1;
`endif
        do_reset();
        w0 = wrap_seen;
        e0 = evt_seen;
        bif.dir = 1'b1;
        press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== exp_dn) begin
            n_err++;
            $display("FAIL wrap_down got %h want %h", got, exp_dn);
        end
        n_cmp++;
        if (wrap_seen - w0 !== exp_w) begin
            n_err++;
            $display("FAIL wrap_down_pulse got %0d want %0d", wrap_seen - w0, exp_w);
        end
        n_cmp++;
        if (evt_seen - e0 !== 1) begin
            n_err++;
            $display("FAIL wrap_down_evt got %0d want 1", evt_seen - e0);
        end
        bif.dir = 1'b0;
        press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== exp_up) begin
            n_err++;
            $display("FAIL wrap_up got %h want %h", got, exp_up);
        end
        n_cmp++;
        if (wrap_seen - w0 !== 2 * exp_w) begin
            n_err++;
            $display("FAIL wrap_up_pulse got %0d want %0d", wrap_seen - w0, 2 * exp_w);
        end
    endtask

    task automatic test_clr();
        int e0;
        do_reset();
        repeat (5) press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h005) begin
            n_err++;
            $display("FAIL clr_preload got %h want 005", got);
        end
        e0 = evt_seen;
        bif.btn_n = 1'b0;
        tick(5);
        bif.clr = 1'b1;
        tick(1);
        bif.clr = 1'b0;
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL clr_digits got %h want 000", got);
        end
        tick(5);
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL clr_held got %h want 000", got);
        end
        n_cmp++;
        if (evt_seen - e0 !== 0) begin
            n_err++;
            $display("FAIL clr_evt got %0d want 0", evt_seen - e0);
        end
        bif.btn_n = 1'b1;
        tick(10);
        press();
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h001) begin
            n_err++;
            $display("FAIL clr_next got %h want 001", got);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        press();
        bif.btn_n = 1'b0;
        tick(4);
        rst = 1'b1;
        #1;
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL rstmid_async got %h want 000", got);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(5);
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h000) begin
            n_err++;
            $display("FAIL rstmid_early got %h want 000", got);
        end
        tick(1);
        got = {bif.centaines, bif.dizaines, bif.unites};
        n_cmp++;
        if (got !== 12'h001) begin
            n_err++;
            $display("FAIL rstmid_fresh got %h want 001", got);
        end
        bif.btn_n = 1'b1;
        tick(10);
    endtask

    initial begin
        bif.btn_n = 1'b1;
        bif.dir = 1'b0;
        bif.clr = 1'b0;
        test_reset();
        test_single();
        test_bounce();
        test_carry();
        test_wrap();
        test_clr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
